// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants, DMA phase encoding and source-page helper
// for the CPU/OAM-DMA memory arbiter.
package gb_mem_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          DMA_LEN      = 160;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;

    localparam logic [7:0]  DMA_LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [7:0]  ECHO_MAX_SRC = 8'hDF;
    localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } dma_state_t;

    // Pages above 0xDF fold back onto work RAM (echo region mirror).
    function automatic logic [7:0] dma_src_page(input logic [7:0] src);
        return (src <= ECHO_MAX_SRC) ? src : (src - ECHO_OFFSET);
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU, memory-port and HRAM-port signals seen by the arbiter; the slave
// modport is the arbiter itself, master is the surrounding system.
interface oam_dma_arbiter_if;

    logic [15:0] i_Cpu_Address;
    logic [7:0]  i_Cpu_Bus;
    logic        i_Cpu_Bus_Out;
    logic        i_Cpu_Bus_In;
    logic [7:0]  o_Cpu_Bus;

    logic [15:0] o_Mem_Address;
    logic [7:0]  o_Mem_Bus;
    logic        o_Mem_Write;
    logic        o_Mem_Read;
    logic [7:0]  i_Mem_Bus;

    logic [6:0]  o_Hram_Address;
    logic        o_Hram_Write;
    logic [7:0]  i_Hram_Bus;

    logic        o_Dma_Active;

    modport slave (
        input  i_Cpu_Address, i_Cpu_Bus, i_Cpu_Bus_Out, i_Cpu_Bus_In,
        input  i_Mem_Bus, i_Hram_Bus,
        output o_Cpu_Bus, o_Mem_Address, o_Mem_Bus, o_Mem_Write, o_Mem_Read,
        output o_Hram_Address, o_Hram_Write, o_Dma_Active
    );

    modport master (
        output i_Cpu_Address, i_Cpu_Bus, i_Cpu_Bus_Out, i_Cpu_Bus_In,
        output i_Mem_Bus, i_Hram_Bus,
        input  o_Cpu_Bus, o_Mem_Address, o_Mem_Bus, o_Mem_Write, o_Mem_Read,
        input  o_Hram_Address, o_Hram_Write, o_Dma_Active
    );

endinterface

// File: rtl/oam_dma_sequencer.sv
// OAM DMA engine: START tick then one READ/WRITE pair per byte (321 enabled
// ticks for a full copy); a stall holds the current phase and index.
module oam_dma_sequencer
    import gb_mem_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic        trigger,
    input  logic [7:0]  src_in,
    input  logic        stall,
    input  logic [7:0]  mem_data,
    output dma_state_t  state,
    output logic [7:0]  src_q,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data,
    output logic        dma_rd,
    output logic        dma_wr,
    output logic        active
);

    dma_state_t state_q, state_nxt;
    logic [7:0] idx_q, idx_nxt;
    logic [7:0] src_nxt;
    logic [7:0] data_q, data_nxt;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            idx_q   <= 8'h00;
            src_q   <= 8'h00;
            data_q  <= 8'h00;
            active  <= 1'b0;
        end else if (i_Enable) begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            src_q   <= src_nxt;
            data_q  <= data_nxt;
            active  <= (state_nxt != IDLE);
        end
    end

    // A register write restarts the copy from any phase, including the last WRITE.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        src_nxt   = src_q;
        data_nxt  = data_q;
        if (trigger) begin
            state_nxt = START;
            idx_nxt   = 8'h00;
            src_nxt   = src_in;
        end else begin
            case (state_q)
                IDLE:  state_nxt = IDLE;
                START: state_nxt = READ;
                READ: begin
                    if (!stall) begin
                        data_nxt  = mem_data;
                        state_nxt = WRITE;
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        if (idx_q == DMA_LAST_IDX) begin
                            state_nxt = IDLE;
                            idx_nxt   = 8'h00;
                        end else begin
                            state_nxt = READ;
                            idx_nxt   = idx_q + 8'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign state    = state_q;
    assign dma_data = data_q;
    assign dma_rd   = (state_q == READ);
    assign dma_wr   = (state_q == WRITE);
    assign dma_addr = (state_q == WRITE) ? (OAM_BASE | {8'h00, idx_q})
                                         : {dma_src_page(src_q), idx_q};

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shares the memory port between CPU and OAM DMA; HRAM is always CPU-owned.
// DMA_BUS_LOCK_EN: DMA owns the port while copying, else CPU accesses stall DMA.
module oam_dma_arbiter
    import gb_mem_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Enable,
    oam_dma_arbiter_if.slave  bus
);

    logic        hit_reg;
    logic        hit_hram;
    logic        hit_other;
    logic        cpu_other_acc;
    logic        dma_phase;
    logic        dma_owns;
    logic        cpu_locked;
    logic        stall;
    logic        trigger;

    dma_state_t  state;
    logic [7:0]  src_q;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        dma_rd;
    logic        dma_wr;
    logic        active;

    assign hit_reg       = (bus.i_Cpu_Address == DMA_REG_ADDR);
    assign hit_hram      = (bus.i_Cpu_Address >= HRAM_LO) && (bus.i_Cpu_Address <= HRAM_HI);
    assign hit_other     = !hit_reg && !hit_hram;
    assign cpu_other_acc = hit_other && (bus.i_Cpu_Bus_In || bus.i_Cpu_Bus_Out);
    assign trigger       = hit_reg && bus.i_Cpu_Bus_Out;
    assign dma_phase     = (state == READ) || (state == WRITE);

`ifdef DMA_BUS_LOCK_EN
    assign dma_owns   = dma_phase;
    assign cpu_locked = dma_phase;
    assign stall      = 1'b0;
`else
    // CPU wins the tick; the sequencer freezes so no DMA strobe is lost.
    assign dma_owns   = dma_phase && !cpu_other_acc;
    assign cpu_locked = 1'b0;
    assign stall      = cpu_other_acc;
`endif

    oam_dma_sequencer u_seq (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Enable (i_Enable),
        .trigger  (trigger),
        .src_in   (bus.i_Cpu_Bus),
        .stall    (stall),
        .mem_data (bus.i_Mem_Bus),
        .state    (state),
        .src_q    (src_q),
        .dma_addr (dma_addr),
        .dma_data (dma_data),
        .dma_rd   (dma_rd),
        .dma_wr   (dma_wr),
        .active   (active)
    );

    always_comb begin
        bus.o_Mem_Address = bus.i_Cpu_Address;
        bus.o_Mem_Bus     = bus.i_Cpu_Bus;
        bus.o_Mem_Read    = hit_other && bus.i_Cpu_Bus_In  && !cpu_locked;
        bus.o_Mem_Write   = hit_other && bus.i_Cpu_Bus_Out && !cpu_locked;
        if (dma_owns) begin
            bus.o_Mem_Address = dma_addr;
            bus.o_Mem_Bus     = dma_data;
            bus.o_Mem_Read    = dma_rd;
            bus.o_Mem_Write   = dma_wr;
        end
    end

    always_comb begin
        bus.o_Cpu_Bus = 8'h00;
        if (bus.i_Cpu_Bus_In) begin
            if (hit_reg)
                bus.o_Cpu_Bus = src_q;
            else if (hit_hram)
                bus.o_Cpu_Bus = bus.i_Hram_Bus;
            else if (cpu_locked)
                bus.o_Cpu_Bus = 8'hFF;
            else
                bus.o_Cpu_Bus = bus.i_Mem_Bus;
        end
    end

    assign bus.o_Hram_Address = bus.i_Cpu_Address[6:0];
    assign bus.o_Hram_Write   = hit_hram && bus.i_Cpu_Bus_Out;
    assign bus.o_Dma_Active   = active;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench: expected DMA strobes are queued at trigger time and
// popped by a memory-port monitor; scenario tasks check CPU-side behaviour.
module tb_oam_dma_arbiter;
    import gb_mem_pkg::*;

`ifdef DMA_BUS_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic i_Clk = 1'b0;
    logic i_Reset;
    logic i_Enable;

    oam_dma_arbiter_if bus ();

    oam_dma_arbiter dut (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Enable (i_Enable),
        .bus      (bus.slave)
    );

    always #5 i_Clk = ~i_Clk;

    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_rd[$];
    wr_t         exp_wr[$];
    bit          tb_cpu_other = 1'b0;
    bit          mem_ovr = 1'b0;
    logic [7:0]  mem_ovr_val = 8'h00;
    logic [15:0] mon_ra;
    wr_t         mon_w;

    // Memory model answers each read with the low address byte.
    assign bus.i_Mem_Bus  = mem_ovr ? mem_ovr_val : bus.o_Mem_Address[7:0];
    assign bus.i_Hram_Bus = 8'h3C;

    always @(negedge i_Clk) begin
        if (i_Enable && !tb_cpu_other) begin
            if (bus.o_Mem_Read) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL dma_read unexpected: addr=%h, none required", bus.o_Mem_Address);
                end else begin
                    mon_ra = exp_rd.pop_front();
                    if (bus.o_Mem_Address !== mon_ra) begin
                        errors++;
                        $display("FAIL dma_read_addr: got %h want %h", bus.o_Mem_Address, mon_ra);
                    end
                end
            end
            if (bus.o_Mem_Write) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL dma_write unexpected: addr=%h data=%h", bus.o_Mem_Address, bus.o_Mem_Bus);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if (bus.o_Mem_Address !== mon_w.a || bus.o_Mem_Bus !== mon_w.d) begin
                        errors++;
                        $display("FAIL dma_write: got %h/%h want %h/%h",
                                 bus.o_Mem_Address, bus.o_Mem_Bus, mon_w.a, mon_w.d);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] tb_page(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - 8'h20) : src;
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_Cpu_Address = 16'h0000;
        bus.i_Cpu_Bus     = 8'h00;
        bus.i_Cpu_Bus_Out = 1'b0;
        bus.i_Cpu_Bus_In  = 1'b0;
        tb_cpu_other      = 1'b0;
        mem_ovr           = 1'b0;
    endtask

    task automatic push_copy(input logic [7:0] src, input int n_rd, input int n_wr);
        for (int i = 0; i < n_rd; i++)
            exp_rd.push_back({tb_page(src), 8'(i)});
        for (int i = 0; i < n_wr; i++)
            exp_wr.push_back(wr_t'{a: 16'hFE00 + 16'(i), d: 8'(i)});
    endtask

    task automatic trigger(input logic [7:0] src);
        bus.i_Cpu_Address = 16'hFF46;
        bus.i_Cpu_Bus     = src;
        bus.i_Cpu_Bus_Out = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic check_reg_read(input string name, input logic [7:0] want);
        bus.i_Cpu_Address = 16'hFF46;
        bus.i_Cpu_Bus_In  = 1'b1;
        #1;
        checks++;
        if (bus.o_Cpu_Bus !== want || bus.o_Mem_Read !== 1'b0) begin
            errors++;
            $display("FAIL %s: cpu_bus=%h mem_rd=%b want %h/0", name, bus.o_Cpu_Bus, bus.o_Mem_Read, want);
        end
        tick();
        idle_inputs();
    endtask

    task automatic wait_wr_left(input int n);
        int g = 0;
        while (exp_wr.size() != n && g < 1000) begin
            tick();
            g++;
        end
        checks++;
        if (g >= 1000) begin
            errors++;
            $display("FAIL wait_writes timeout: left=%0d want %0d", exp_wr.size(), n);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL %s drained: reads left %0d writes left %0d want 0/0",
                     name, exp_rd.size(), exp_wr.size());
        end
        exp_rd.delete();
        exp_wr.delete();
    endtask

    // Runs until o_Dma_Active drops, counting enabled ticks; optionally inserts
    // CPU reads of 0xC000, an HRAM write and a clock-enable gap.
    task automatic run_to_idle(input int n_ins, input int gap_at, output int ticks);
        int ins = 0;
        logic [15:0] held;
        ticks = 0;
        while (bus.o_Dma_Active && ticks < 2000) begin
            idle_inputs();
            i_Enable = 1'b1;
            if (ins < n_ins && ticks == 40 + 6 * ins) begin
                bus.i_Cpu_Address = 16'hC000;
                bus.i_Cpu_Bus_In  = 1'b1;
                tb_cpu_other      = !LOCK;
                mem_ovr           = !LOCK;
                mem_ovr_val       = 8'h77;
                #1;
                checks++;
                if (LOCK) begin
                    if (bus.o_Cpu_Bus !== 8'hFF || bus.o_Mem_Address === 16'hC000) begin
                        errors++;
                        $display("FAIL locked_cpu_read: cpu_bus=%h mem_addr=%h want FF/not C000",
                                 bus.o_Cpu_Bus, bus.o_Mem_Address);
                    end
                end else begin
                    if (bus.o_Cpu_Bus !== 8'h77 || bus.o_Mem_Address !== 16'hC000 ||
                        bus.o_Mem_Read !== 1'b1 || bus.o_Mem_Write !== 1'b0) begin
                        errors++;
                        $display("FAIL cpu_priority_read: cpu_bus=%h addr=%h rd=%b wr=%b want 77/C000/1/0",
                                 bus.o_Cpu_Bus, bus.o_Mem_Address, bus.o_Mem_Read, bus.o_Mem_Write);
                    end
                end
                ins++;
            end else if (n_ins > 0 && ticks == 30) begin
                bus.i_Cpu_Address = 16'hFF85;
                bus.i_Cpu_Bus     = 8'hAB;
                bus.i_Cpu_Bus_Out = 1'b1;
                #1;
                checks++;
                if (bus.o_Hram_Write !== 1'b1 || bus.o_Hram_Address !== 7'h05) begin
                    errors++;
                    $display("FAIL hram_write_during_dma: wr=%b addr=%h want 1/05",
                             bus.o_Hram_Write, bus.o_Hram_Address);
                end
            end else if (gap_at > 0 && ticks == gap_at) begin
                i_Enable = 1'b0;
                held = bus.o_Mem_Address;
                repeat (3) tick();
                checks++;
                if (bus.o_Mem_Address !== held) begin
                    errors++;
                    $display("FAIL enable_hold: addr=%h want %h", bus.o_Mem_Address, held);
                end
                i_Enable = 1'b1;
            end
            ticks++;
            tick();
        end
        idle_inputs();
        if (ticks >= 2000) begin
            checks++;
            errors++;
            $display("FAIL dma_timeout: ticks=%0d still active", ticks);
        end
    endtask

    task automatic test_reset();
        i_Enable = 1'b1;
        i_Reset  = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (bus.o_Dma_Active !== 1'b0 || bus.o_Mem_Read !== 1'b0 || bus.o_Mem_Write !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: active=%b rd=%b wr=%b want 0/0/0",
                     bus.o_Dma_Active, bus.o_Mem_Read, bus.o_Mem_Write);
        end
        i_Reset = 1'b0;
        tick();
        bus.i_Cpu_Address = 16'hC000;
        bus.i_Cpu_Bus_In  = 1'b1;
        tb_cpu_other      = 1'b1;
        mem_ovr           = 1'b1;
        mem_ovr_val       = 8'h5A;
        #1;
        checks++;
        if (bus.o_Mem_Read !== 1'b1 || bus.o_Mem_Address !== 16'hC000 ||
            bus.o_Cpu_Bus !== 8'h5A || bus.o_Dma_Active !== 1'b0) begin
            errors++;
            $display("FAIL idle_cpu_read: rd=%b addr=%h data=%h active=%b want 1/C000/5A/0",
                     bus.o_Mem_Read, bus.o_Mem_Address, bus.o_Cpu_Bus, bus.o_Dma_Active);
        end
        tick();
        idle_inputs();
        bus.i_Cpu_Address = 16'hFF90;
        bus.i_Cpu_Bus_In  = 1'b1;
        #1;
        checks++;
        if (bus.o_Cpu_Bus !== 8'h3C || bus.o_Mem_Read !== 1'b0 || bus.o_Hram_Address !== 7'h10) begin
            errors++;
            $display("FAIL hram_read: data=%h mem_rd=%b addr=%h want 3C/0/10",
                     bus.o_Cpu_Bus, bus.o_Mem_Read, bus.o_Hram_Address);
        end
        bus.i_Cpu_Bus_In = 1'b0;
        #1;
        checks++;
        if (bus.o_Cpu_Bus !== 8'h00) begin
            errors++;
            $display("FAIL cpu_bus_not_reading: got %h want 00", bus.o_Cpu_Bus);
        end
        tick();
        idle_inputs();
        check_reg_read("reset_src", 8'h00);
    endtask

    task automatic test_full_copy(input logic [7:0] src, input int gap_at);
        int t;
        push_copy(src, DMA_LEN, DMA_LEN);
        trigger(src);
        checks++;
        if (bus.o_Dma_Active !== 1'b1) begin
            errors++;
            $display("FAIL active_after_trigger: got %b want 1", bus.o_Dma_Active);
        end
        run_to_idle(0, gap_at, t);
        checks++;
        if (t != 321) begin
            errors++;
            $display("FAIL copy_duration: got %0d want 321", t);
        end
        check_drained("full_copy");
        check_reg_read("src_readback", src);
    endtask

    task automatic test_cpu_during_dma();
        int t;
        int want;
        want = LOCK ? 321 : 331;
        push_copy(8'hC1, DMA_LEN, DMA_LEN);
        trigger(8'hC1);
        run_to_idle(10, 0, t);
        checks++;
        if (t != want) begin
            errors++;
            $display("FAIL shared_duration: got %0d want %0d", t, want);
        end
        check_drained("cpu_during_dma");
    endtask

    task automatic test_restart();
        int t;
        push_copy(8'hC1, 81, 80);
        trigger(8'hC1);
        wait_wr_left(0);
        push_copy(8'hC2, DMA_LEN, DMA_LEN);
        trigger(8'hC2);
        run_to_idle(0, 0, t);
        checks++;
        if (t != 321) begin
            errors++;
            $display("FAIL restart_duration: got %0d want 321", t);
        end
        check_drained("restart");
    endtask

    task automatic test_back_to_back();
        int t;
        push_copy(8'hC1, DMA_LEN, DMA_LEN);
        trigger(8'hC1);
        wait_wr_left(1);
        tick();
        push_copy(8'hC3, DMA_LEN, DMA_LEN);
        trigger(8'hC3);
        checks++;
        if (bus.o_Dma_Active !== 1'b1) begin
            errors++;
            $display("FAIL trigger_on_last_write: active=%b want 1", bus.o_Dma_Active);
        end
        run_to_idle(0, 0, t);
        checks++;
        if (t != 321) begin
            errors++;
            $display("FAIL back_to_back_duration: got %0d want 321", t);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid();
        push_copy(8'hC1, 40, 40);
        trigger(8'hC1);
        wait_wr_left(0);
        i_Reset = 1'b1;
        #1;
        checks++;
        if (bus.o_Dma_Active !== 1'b0 || bus.o_Mem_Read !== 1'b0 || bus.o_Mem_Write !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: active=%b rd=%b wr=%b want 0/0/0",
                     bus.o_Dma_Active, bus.o_Mem_Read, bus.o_Mem_Write);
        end
        tick();
        tick();
        i_Reset = 1'b0;
        repeat (20) tick();
        checks++;
        if (bus.o_Dma_Active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stays_idle: active=%b want 0", bus.o_Dma_Active);
        end
        check_drained("reset_mid");
        check_reg_read("reset_mid_src", 8'h00);
    endtask

    initial begin
        test_reset();
        test_full_copy(8'hC1, 0);
        test_full_copy(8'hF0, 100);
        test_cpu_during_dma();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Owns the single external memory port and shares it between the CPU core and the OAM DMA engine. CPU writes to 0xFF46 start a 160-byte copy from `{src,8'h00}` to 0xFE00–0xFE9F. While the copy runs, the block sequences one read/write pair per byte and gates CPU access. HRAM (0xFF80–0xFFFE) sits on a private port so the CPU can always reach it. Placed between the CPU address/bus pins and the memory map decoder.

## Interface

Parameters:
- none; all constants live in the shared package.

Ports:
- `i_Clk`  in  1  system clock
- `i_Reset`  in  1  asynchronous, active-high reset
- `i_Enable`  in  1  clock enable; state advances only on enabled edges
- `i_Cpu_Address`  in  16  CPU address
- `i_Cpu_Bus`  in  8  CPU write data
- `i_Cpu_Bus_Out`  in  1  CPU write strobe
- `i_Cpu_Bus_In`  in  1  CPU read strobe
- `o_Cpu_Bus`  out  8  read data returned to CPU
- `o_Mem_Address`  out  16  memory port address
- `o_Mem_Bus`  out  8  memory port write data
- `o_Mem_Write`  out  1  memory port write strobe
- `o_Mem_Read`  out  1  memory port read strobe
- `i_Mem_Bus`  in  8  memory port read data
- `o_Hram_Address`  out  7  HRAM offset (`i_Cpu_Address[6:0]`)
- `o_Hram_Write`  out  1  HRAM write strobe
- `i_Hram_Bus`  in  8  HRAM read data
- `o_Dma_Active`  out  1  high from trigger until last byte written

## Operation

- Decode:
  - HIT_REG: address == 0xFF46.
  - HIT_HRAM: address in 0xFF80–0xFFFE.
  - OTHER: everything else.
- HIT_REG write on an enabled edge: load `src_q`, clear `idx` to 0, enter START. A write while busy restarts the copy.
- HIT_REG is never forwarded to the memory port. HIT_REG reads return `src_q`.
- HIT_HRAM is always serviced on the HRAM port:
  - `o_Hram_Write = i_Cpu_Bus_Out`.
  - `o_Cpu_Bus = i_Hram_Bus`.
- State machine:
  - IDLE -> START on trigger.
  - START -> READ.
  - READ -> WRITE.
  - WRITE -> READ while `idx` < 159, incrementing `idx`.
  - WRITE -> IDLE when `idx` == 159.
- READ phase:
  - `o_Mem_Address = eff_src<<8 | idx`, `o_Mem_Read = 1`.
  - `i_Mem_Bus` is latched into `data_q` at the end of the phase.
- WRITE phase:
  - `o_Mem_Address = 0xFE00 | idx`, `o_Mem_Bus = data_q`, `o_Mem_Write = 1`.
- `eff_src = src_q` when `src_q` ≤ 0xDF; otherwise `src_q - 0x20` (echo-RAM mirror). `idx` is 8 bits, range 0–159. The high address byte is never carried into.
- Memory port passthrough: in IDLE and START, OTHER CPU accesses drive the memory port combinationally.
  - `o_Mem_Address = i_Cpu_Address`.
  - `o_Mem_Read = i_Cpu_Bus_In`, `o_Mem_Write = i_Cpu_Bus_Out`, `o_Mem_Bus = i_Cpu_Bus`.
  - `o_Cpu_Bus = i_Mem_Bus`.
- `o_Cpu_Bus` is 0x00 when the CPU is not reading.

## Timing

- Reset values:
  - State IDLE, `idx` = 0, `src_q` = 0x00, `data_q` = 0x00, `o_Dma_Active` = 0.
  - Memory and HRAM outputs are pure passthrough of CPU inputs.
- Reset mid-transfer aborts immediately. No further DMA strobes are issued, and already-written OAM bytes are kept.
- `o_Dma_Active` is registered: high on the enabled edge after the trigger, low on the edge after the WRITE of `idx` 159.
- Latency: trigger edge, then 1 START tick, then 320 READ/WRITE ticks. The full copy is 321 enabled ticks.
- With `i_Enable` low, all registers hold and combinational outputs reflect the current state.
- A trigger on the same edge as WRITE of `idx` 159: the trigger wins and the block goes to START.

## Configuration

- `DMA_BUS_LOCK_EN` defined (hardware-accurate):
  - In READ/WRITE, DMA owns the memory port.
  - CPU OTHER reads return 0xFF and CPU OTHER writes are dropped.
  - HIT_REG and HIT_HRAM are unaffected.
- Undefined (CPU priority):
  - In READ/WRITE, an OTHER CPU access on a tick passes through, and DMA holds its phase and `idx` for that tick.
  - DMA strobes appear only on ticks with no OTHER CPU access.
  - Total duration grows by the number of stalled ticks.

## Structure

- Package `gb_mem_pkg`:
  - Constants `DMA_REG_ADDR` = 16'hFF46, `OAM_BASE` = 16'hFE00, `DMA_LEN` = 160, `HRAM_LO` = 16'hFF80, `HRAM_HI` = 16'hFFFE.
  - State typedef `dma_state_t` {IDLE, START, READ, WRITE}.
- One sub-module, `oam_dma_sequencer`, holds the state, `idx`, `src_q` and `data_q`. It outputs the phase and the DMA address/data.
- The top level does address decode and port muxing.

## Test plan

- Reset, then CPU read of 0xC000 with `i_Mem_Bus`=0x5A -> `o_Mem_Read`=1, `o_Mem_Address`=0xC000, `o_Cpu_Bus`=0x5A, `o_Dma_Active`=0.
- Write 0xC1 to 0xFF46, memory model returns the low address byte -> 160 writes at 0xFE00..0xFE9F with data 0x00..0x9F from reads at 0xC100..0xC19F. `o_Dma_Active` is high for exactly 321 enabled ticks. A read of 0xFF46 returns 0xC1.
- Trigger with 0xF0 -> reads start at 0xD000.
- With lock, CPU read of 0xC000 during DMA -> 0xFF and no extra memory strobe. A concurrent HRAM write of 0xAB to 0xFF85 -> `o_Hram_Write`=1, `o_Hram_Address`=0x05.
- Re-trigger with 0xC2 at `idx` 80 -> START, then reads from 0xC200. Assert `i_Reset` at `idx` 40 -> `o_Dma_Active`=0 immediately and no strobes after.
- Without lock, 10 CPU reads of 0xC000 inserted mid-DMA -> all pass through, and the copy completes in 331 ticks.
